rr_arbiter4: RTL and testbench

Four-requester arbiter that shares one downstream resource (bus slot, encoder output, shared unit) between requesters `req[3:0]`. It issues a registered one-hot grant plus encoded index, holds the grant until the holder releases it, and can forcibly revoke a grant after a programmable hold limit. Default arbitration is round-robin. With round-robin disabled it reduces to fixed priority, index 3 highest.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/rr_arbiter4.sv | 88 ++++++++
 tb/tb_rr_arbiter4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way grant arbiter.
// Holds the arbiter state enum, requester count/index width and index type,
// plus a helper that turns an encoded index into a one-hot vector.
package arb_pkg;

   localparam int ARB_N   = 4;
   localparam int ARB_IDW = 2;

   typedef logic [ARB_IDW-1:0] arb_id_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   function automatic logic [ARB_N-1:0] arb_onehot(input arb_id_t id);
      logic [ARB_N-1:0] vec;
      vec     = '0;
      vec[id] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority winner pick over four level requests (purely combinational, zero latency).
// Ports: req[3:0] requests, ptr[1:0] highest-priority index; win_id[1:0] winner, win_vld any request.
// No backpressure: the result follows the inputs within the same cycle.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0] req,
   input  arb_id_t          ptr,
   output arb_id_t          win_id,
   output logic             win_vld
);

   arb_id_t idx;

   // Search order is ptr, ptr-1, ptr-2, ptr-3. Walking it backwards lets the
   // highest-priority set bit overwrite the lower ones without an early exit.
   always_comb begin
      win_id  = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = ARB_N - 1; i >= 0; i--) begin
         idx = ptr - arb_id_t'(i);
         if (req[idx]) begin
            win_id  = idx;
            win_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester grant arbiter with hold-until-release and optional hold-limit revocation.
// Ports: clk, rst_n (async low), req[3:0], done in; gnt[3:0], gnt_id[1:0], busy, timeout out (all registered).
// Latency: grant one edge after req is seen idle; release one edge after done/req-drop/limit; no preemption.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter bit RR_EN    = 1'b1,
   parameter int MAX_HOLD = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ARB_N-1:0] req,
   input  logic             done,
   output logic [ARB_N-1:0] gnt,
   output arb_id_t          gnt_id,
   output logic             busy,
   output logic             timeout
);

   // Counter still needs one bit when the hold limit is disabled.
   localparam int            CW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam arb_id_t       PTR_TOP = arb_id_t'(ARB_N - 1);

   arb_state_t    state;
   arb_id_t       ptr;
   logic [CW-1:0] hold_cnt;

   arb_id_t win_id;
   logic    win_vld;
   logic    holder_req;
   logic    hold_lim;
   logic    rel;

   rr_pick4 u_pick (
      .req     (req),
      .ptr     (ptr),
      .win_id  (win_id),
      .win_vld (win_vld)
   );

   assign holder_req = req[gnt_id];
   assign hold_lim   = (MAX_HOLD > 0) && (hold_cnt == LAST);
   assign rel        = done || !holder_req || hold_lim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         ptr      <= PTR_TOP;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (win_vld) begin
                  state    <= ARB_GRANT;
                  gnt      <= arb_onehot(win_id);
                  gnt_id   <= win_id;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  // Last winner drops to lowest priority in rotating mode.
                  ptr      <= RR_EN ? arb_id_t'(win_id - 1'b1) : PTR_TOP;
               end
            end
            ARB_GRANT: begin
               if (rel) begin
                  state   <= ARB_IDLE;
                  gnt     <= '0;
                  gnt_id  <= '0;
                  busy    <= 1'b0;
                  // Only a pure limit expiry counts as a revocation; a
                  // coincident done or request drop is a normal release.
                  timeout <= hold_lim && !done && holder_req;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: rotating instance (MAX_HOLD=8) and fixed-priority instance (no limit).
// Stimulus pushes expected grants {dut, gnt, length, timeout, idle gap}; a negedge monitor pops on each new grant.
// Every wait on the design is bounded; expiries are reported as failures.
module tb_rr_arbiter4;

   typedef struct {
      int         d;
      logic [3:0] gnt;
      int         len;
      bit         to;
      int         gap;   // 0 = idle gap not checked
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [1:0][3:0] req_s;
   logic [1:0]      done_s;
   logic [1:0][3:0] gnt_o;
   logic [1:0][1:0] gid_o;
   logic [1:0]      bsy_o;
   logic [1:0]      tmo_o;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   rr_arbiter4 #(.RR_EN(1'b1), .MAX_HOLD(8)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req(req_s[0]), .done(done_s[0]),
      .gnt(gnt_o[0]), .gnt_id(gid_o[0]), .busy(bsy_o[0]), .timeout(tmo_o[0])
   );

   rr_arbiter4 #(.RR_EN(1'b0), .MAX_HOLD(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req(req_s[1]), .done(done_s[1]),
      .gnt(gnt_o[1]), .gnt_id(gid_o[1]), .busy(bsy_o[1]), .timeout(tmo_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] enc(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic void push(input int d, input logic [3:0] g, input int len,
                                input bit to, input int gap);
      exp_t e;
      e.d = d; e.gnt = g; e.len = len; e.to = to; e.gap = gap;
      q.push_back(e);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_busy(input int d);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bsy_o[d]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL wait_busy dut%0d: busy=0 expected=1 within 30 cycles", d);
      end
   endtask

   task automatic wait_idle(input int d);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (!bsy_o[d]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL wait_idle dut%0d: busy=1 expected=0 within 30 cycles", d);
      end
   endtask

   // Hold the grant for exactly len cycles, releasing with a done pulse.
   task automatic serve(input int d, input int len);
      wait_busy(d);
      repeat (len - 1) begin @(posedge clk); #1; end
      done_s[d] = 1'b1;
      @(posedge clk); #1;
      done_s[d] = 1'b0;
   endtask

   // Monitor: per-cycle consistency, grant identity on rise, length/timeout on fall.
   initial begin
      bit   prev [2];
      bit   act  [2];
      int   len_c[2];
      int   gap_c[2];
      exp_t cur  [2];
      bit   rise, fall;
      for (int d = 0; d < 2; d++) begin
         prev[d] = 1'b0; act[d] = 1'b0; len_c[d] = 0; gap_c[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("id_enc%0d", d), gid_o[d], enc(gnt_o[d]));
            chk($sformatf("busy_or%0d", d), bsy_o[d], |gnt_o[d]);
            rise = bsy_o[d] && !prev[d];
            fall = !bsy_o[d] && prev[d];
            if (rise) begin
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL grant_unexpected dut%0d: gnt=%b expected no grant", d, gnt_o[d]);
               end else begin
                  cur[d] = q.pop_front();
                  act[d] = 1'b1;
                  chk("grant_dut", d, cur[d].d);
                  chk($sformatf("gnt%0d", d), gnt_o[d], cur[d].gnt);
                  chk($sformatf("gnt_id%0d", d), gid_o[d], enc(cur[d].gnt));
                  if (cur[d].gap > 0) chk($sformatf("idle_gap%0d", d), gap_c[d], cur[d].gap);
               end
               len_c[d] = 1;
            end else if (bsy_o[d]) begin
               len_c[d]++;
            end
            if (fall && act[d]) begin
               chk($sformatf("grant_len%0d", d), len_c[d], cur[d].len);
               chk($sformatf("timeout_fall%0d", d), tmo_o[d], cur[d].to);
               act[d]   = 1'b0;
               gap_c[d] = 1;
            end else begin
               chk($sformatf("timeout_quiet%0d", d), tmo_o[d], 1'b0);
               if (!bsy_o[d]) gap_c[d]++;
            end
            prev[d] = bsy_o[d];
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      req_s  = '0;
      done_s = '0;
      tick(2);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_gnt%0d", d), gnt_o[d], 4'b0000);
         chk($sformatf("rst_gid%0d", d), gid_o[d], 2'd0);
         chk($sformatf("rst_busy%0d", d), bsy_o[d], 1'b0);
         chk($sformatf("rst_tmo%0d", d), tmo_o[d], 1'b0);
      end
      rst_n = 1'b1;
      tick(1);

      // Rotating: ptr=3 picks 2, then ptr=1 picks 0, alternating.
      push(0, 4'b0100, 3, 1'b0, 0);
      push(0, 4'b0001, 2, 1'b0, 1);
      push(0, 4'b0100, 1, 1'b0, 1);
      push(0, 4'b0001, 2, 1'b0, 1);
      req_s[0] = 4'b0101;
      serve(0, 3); serve(0, 2); serve(0, 1); serve(0, 2);
      req_s[0] = 4'b0000;
      tick(3);

      // Hold limit: revoked after 8 cycles, re-granted; done on 8th cycle beats the limit.
      push(0, 4'b0010, 8, 1'b1, 0);
      push(0, 4'b0010, 8, 1'b0, 1);
      req_s[0] = 4'b0010;
      wait_busy(0);
      wait_idle(0);
      serve(0, 8);
      req_s[0] = 4'b0000;
      tick(3);

      // Holder drops its request while requester 3 waits; 3 is served after one idle cycle.
      push(0, 4'b0010, 2, 1'b0, 0);
      push(0, 4'b1000, 2, 1'b0, 1);
      req_s[0] = 4'b0010;
      wait_busy(0);
      req_s[0] = 4'b1010;
      tick(1);
      req_s[0] = 4'b1000;
      serve(0, 2);
      req_s[0] = 4'b0000;
      tick(3);

      // Asynchronous reset in the middle of a grant, then fixed-priority first pick.
      push(0, 4'b0100, 1, 1'b0, 0);
      req_s[0] = 4'b0100;
      wait_busy(0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", gnt_o[0], 4'b0000);
      chk("arst_gid", gid_o[0], 2'd0);
      chk("arst_busy", bsy_o[0], 1'b0);
      chk("arst_tmo", tmo_o[0], 1'b0);
      req_s[0] = 4'b0000;
      tick(2);
      rst_n = 1'b1;
      push(0, 4'b0010, 1, 1'b0, 0);
      req_s[0] = 4'b0011;
      serve(0, 1);
      req_s[0] = 4'b0000;
      tick(3);

      // Fixed priority, no hold limit: 3 always wins, even for a 12-cycle hold.
      push(1, 4'b1000, 2, 1'b0, 0);
      push(1, 4'b1000, 1, 1'b0, 1);
      push(1, 4'b1000, 3, 1'b0, 1);
      push(1, 4'b1000, 12, 1'b0, 1);
      req_s[1] = 4'b1111;
      serve(1, 2); serve(1, 1); serve(1, 3); serve(1, 12);
      req_s[1] = 4'b0000;
      tick(5);

      chk("queue_drained", q.size(), 0);
      chk("busy_end_rr", bsy_o[0], 1'b0);
      chk("busy_end_fp", bsy_o[1], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
